cell_renderer: RTL and testbench

CELL_RENDERER -- requirements
Module: cell_renderer

---
 rtl/cell_renderer.sv | 201 ++++++++++++++++++++
 tb/tb_cell_renderer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_renderer.sv
// Cell renderer: turns sync-generator counters into cell RAM reads and registered VGA colour.
// Latency: counter-to-RGB 2 clk, sync-to-VGA-sync 2 clk; cell_addr 1 clk after the counters.
// Backpressure: none (pixel-rate stream); bank swap via swap_req/swap_ack handshake at frame end.
//
// Ports: clk/rst_n (async active-low); counter_x/counter_y/in_display_area/h_sync_in/v_sync_in
// from the sync generator; cell_addr/cell_bank/cell_rd_data to the cell RAM; cursor_x/cursor_y/
// show_grid overlay controls; swap_req/swap_ack/frame_end to the life engine; vga_* outputs.
module cell_renderer #(
    parameter int CELL_SHIFT = 3,
    parameter int GRID_W     = 80,
    parameter int GRID_H     = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  counter_x,
    input  logic [8:0]  counter_y,
    input  logic        in_display_area,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [12:0] cell_addr,
    output logic        cell_bank,
    input  logic        cell_rd_data,
    input  logic [6:0]  cursor_x,
    input  logic [5:0]  cursor_y,
    input  logic        show_grid,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_end,
    output logic [2:0]  vga_r,
    output logic [2:0]  vga_g,
    output logic [1:0]  vga_b,
    output logic        vga_h_sync,
    output logic        vga_v_sync
);

    localparam logic [9:0]  GW     = 10'(GRID_W);
    localparam logic [8:0]  GH     = 9'(GRID_H);
    localparam logic [12:0] GW13   = 13'(GRID_W);
    localparam logic [8:0]  LAST_Y = 9'((GRID_H << CELL_SHIFT) - 1);
    localparam logic [CELL_SHIFT-1:0] OFF_MAX = '1;

    typedef enum logic [1:0] {ARMED, PENDING, WAIT_LOW} swap_state_t;

    // row*GRID_W as a sum of shifted copies of row, one per set bit of GRID_W
    function automatic logic [12:0] row_base(input logic [12:0] r);
        logic [12:0] acc;
        acc = '0;
        for (int i = 0; i < 13; i++) begin
            if (GW13[i]) acc = acc + (r << i);
        end
        return acc;
    endfunction

    logic [9:0]  col;
    logic [8:0]  row;
    logic        in_grid;
    logic        cursor_ok;
    logic        on_cursor;
    logic [12:0] addr_next;

    assign col       = counter_x >> CELL_SHIFT;
    assign row       = counter_y >> CELL_SHIFT;
    assign in_grid   = (col < GW) && (row < GH);
    assign cursor_ok = ({3'b000, cursor_x} < GW) && ({3'b000, cursor_y} < GH);
    assign on_cursor = cursor_ok && (col == {3'b000, cursor_x}) && (row == {3'b000, cursor_y});
    assign addr_next = row_base(13'(row)) + 13'(col);

    // Stage 0: address plus per-pixel flags travelling alongside the RAM read
    logic                  s0_de;
    logic                  s0_in_grid;
    logic                  s0_cursor;
    logic                  s0_grid;
    logic [CELL_SHIFT-1:0] s0_offx;
    logic [CELL_SHIFT-1:0] s0_offy;
    logic                  h_d1;
    logic                  v_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_addr  <= '0;
            s0_de      <= 1'b0;
            s0_in_grid <= 1'b0;
            s0_cursor  <= 1'b0;
            s0_grid    <= 1'b0;
            s0_offx    <= '0;
            s0_offy    <= '0;
            h_d1       <= 1'b0;
            v_d1       <= 1'b0;
        end else begin
            // Off-grid pixels keep the last address so the RAM never sees an out-of-range read
            if (in_grid) cell_addr <= addr_next;
            s0_de      <= in_display_area;
            s0_in_grid <= in_grid;
            s0_cursor  <= on_cursor;
            s0_grid    <= show_grid;
            s0_offx    <= counter_x[CELL_SHIFT-1:0];
            s0_offy    <= counter_y[CELL_SHIFT-1:0];
            h_d1       <= h_sync_in;
            v_d1       <= v_sync_in;
        end
    end

    // Stage 1: cell_rd_data for the stage-0 pixel arrives now and is folded into the colour
    logic [2:0] col_r;
    logic [2:0] col_g;
    logic [1:0] col_b;
    logic       border;
    logic       grid_line;

    assign border    = (s0_offx == '0) || (s0_offx == OFF_MAX) ||
                       (s0_offy == '0) || (s0_offy == OFF_MAX);
    assign grid_line = (s0_offx == '0) || (s0_offy == '0);

    always_comb begin
        col_r = 3'd0;
        col_g = 3'd0;
        col_b = 2'd0;
        if (!s0_de) begin
            col_r = 3'd0;
        end else if (s0_cursor && border) begin
            col_r = 3'd7;
        end else if (s0_grid && grid_line) begin
            col_r = 3'd1;
            col_g = 3'd1;
            col_b = 2'd1;
        end else if (s0_in_grid && cell_rd_data) begin
            col_g = 3'd7;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            vga_h_sync <= 1'b0;
            vga_v_sync <= 1'b0;
        end else begin
            vga_r      <= col_r;
            vga_g      <= col_g;
            vga_b      <= col_b;
            vga_h_sync <= h_d1;
            vga_v_sync <= v_d1;
        end
    end

    // Frame end: display enable falling on the last visible line. s0_de is the previous
    // cycle's enable; it clears on reset so no event can fire on the first cycle after release.
    logic fe_evt;
    assign fe_evt = s0_de && !in_display_area && (counter_y == LAST_Y);

    swap_state_t state;
    swap_state_t state_nxt;
    logic        do_swap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARMED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        case (state)
            ARMED: begin
                if (swap_req) begin
                    if (fe_evt) begin
                        do_swap   = 1'b1;
                        state_nxt = WAIT_LOW;
                    end else begin
                        state_nxt = PENDING;
                    end
                end
            end
            PENDING: begin
                // A dropped request does not cancel: the engine already committed a new buffer
                if (fe_evt) begin
                    do_swap   = 1'b1;
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!swap_req) state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_bank <= 1'b0;
            swap_ack  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            cell_bank <= cell_bank ^ do_swap;
            swap_ack  <= do_swap;
            frame_end <= fe_evt;
        end
    end

endmodule

// File: tb/tb_cell_renderer.sv
// Self-checking bench for cell_renderer: random pixels against a per-pixel reference model,
// plus directed address/colour/cursor cases and the frame-end buffer swap handshake.
// Outputs are compared 1 time unit after each rising edge.
module tb_cell_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  counter_x;
    logic [8:0]  counter_y;
    logic        in_display_area;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [12:0] cell_addr;
    logic        cell_bank;
    logic        cell_rd_data;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        show_grid;
    logic        swap_req;
    logic        swap_ack;
    logic        frame_end;
    logic [2:0]  vga_r;
    logic [2:0]  vga_g;
    logic [1:0]  vga_b;
    logic        vga_h_sync;
    logic        vga_v_sync;

    always #5 clk = ~clk;

    cell_renderer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .counter_x       (counter_x),
        .counter_y       (counter_y),
        .in_display_area (in_display_area),
        .h_sync_in       (h_sync_in),
        .v_sync_in       (v_sync_in),
        .cell_addr       (cell_addr),
        .cell_bank       (cell_bank),
        .cell_rd_data    (cell_rd_data),
        .cursor_x        (cursor_x),
        .cursor_y        (cursor_y),
        .show_grid       (show_grid),
        .swap_req        (swap_req),
        .swap_ack        (swap_ack),
        .frame_end       (frame_end),
        .vga_r           (vga_r),
        .vga_g           (vga_g),
        .vga_b           (vga_b),
        .vga_h_sync      (vga_h_sync),
        .vga_v_sync      (vga_v_sync)
    );

    typedef struct {
        int x;
        int y;
        bit de;
        bit hs;
        bit vs;
        bit grid;
        bit rd;
        bit req;
        int cx;
        int cy;
    } px_t;

    px_t cur;
    px_t p1;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [12:0] m_addr;
    logic [7:0]  m_rgb;
    bit          m_bank, m_ack, m_fe, m_hs, m_vs;
    bit          m_prev_de;
    bit          m_owed;   // a request has been seen and not yet honoured
    bit          m_lock;   // swap done, waiting for the request to drop

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Colour of one pixel from the cell/cursor/grid rules, 8x8 cells on an 80x60 grid
    function automatic logic [7:0] colour(input px_t a, input bit rd);
        int col, row, ox, oy;
        bit hit;
        col = a.x / 8;
        row = a.y / 8;
        ox  = a.x % 8;
        oy  = a.y % 8;
        hit = (a.cx < 80) && (a.cy < 60) && (col == a.cx) && (row == a.cy);
        if (!a.de) return 8'd0;
        if (hit && (ox == 0 || ox == 7 || oy == 0 || oy == 7)) return {3'd7, 3'd0, 2'd0};
        if (a.grid && (ox == 0 || oy == 0)) return {3'd1, 3'd1, 2'd1};
        if (col < 80 && row < 60 && rd) return {3'd0, 3'd7, 2'd0};
        return 8'd0;
    endfunction

    task automatic drive();
        counter_x       = 10'(cur.x);
        counter_y       = 9'(cur.y);
        in_display_area = cur.de;
        h_sync_in       = cur.hs;
        v_sync_in       = cur.vs;
        show_grid       = cur.grid;
        cell_rd_data    = cur.rd;
        swap_req        = cur.req;
        cursor_x        = 7'(cur.cx);
        cursor_y        = 6'(cur.cy);
    endtask

    task automatic model_reset();
        p1        = '{default: 0};
        m_addr    = '0;
        m_rgb     = '0;
        m_bank    = 0;
        m_ack     = 0;
        m_fe      = 0;
        m_hs      = 0;
        m_vs      = 0;
        m_prev_de = 0;
        m_owed    = 0;
        m_lock    = 0;
    endtask

    task automatic check_all();
        chk("cell_addr", 16'(cell_addr), 16'(m_addr));
        chk("rgb", 16'({vga_r, vga_g, vga_b}), 16'(m_rgb));
        chk("h_sync", 16'(vga_h_sync), 16'(m_hs));
        chk("v_sync", 16'(vga_v_sync), 16'(m_vs));
        chk("cell_bank", 16'(cell_bank), 16'(m_bank));
        chk("swap_ack", 16'(swap_ack), 16'(m_ack));
        chk("frame_end", 16'(frame_end), 16'(m_fe));
    endtask

    // Apply cur for one clock, advance the model, compare every output after the edge
    task automatic tick();
        bit evt, sw;
        int col, row;
        drive();
        evt = m_prev_de && !cur.de && (cur.y == 479);
        sw  = 0;
        if (m_lock) begin
            if (!cur.req) m_lock = 0;
        end else if (m_owed || cur.req) begin
            if (evt) begin
                sw     = 1;
                m_owed = 0;
                m_lock = 1;
            end else begin
                m_owed = 1;
            end
        end
        m_bank = m_bank ^ sw;
        m_ack  = sw;
        m_fe   = evt;
        m_rgb  = colour(p1, cur.rd);
        m_hs   = p1.hs;
        m_vs   = p1.vs;
        col = cur.x / 8;
        row = cur.y / 8;
        if (col < 80 && row < 60) m_addr = 13'(row * 80 + col);
        m_prev_de = cur.de;
        p1 = cur;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Last visible line ends: enable high then low on line 479, then next frame starts
    task automatic frame_event();
        cur.y = 479; cur.x = 600; cur.de = 1;
        tick();
        cur.x = 640; cur.de = 0;
        tick();
    endtask

    initial begin
        cur = '{default: 0};
        cur.cx = 100;
        rst_n = 1'b0;
        drive();
        #12;
        model_reset();
        check_all();
        chk("rst_bank", 16'(cell_bank), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random pixels, cursor often under the beam, occasional last-line falls and requests
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0) begin
                cur.cx = int'($urandom_range(127));
                cur.cy = int'($urandom_range(63));
            end
            if ($urandom_range(1) == 1) begin
                cur.x = cur.cx * 8 + int'($urandom_range(7));
                cur.y = cur.cy * 8 + int'($urandom_range(7));
            end else begin
                cur.x = int'($urandom_range(1023));
                cur.y = ($urandom_range(7) == 0) ? 479 : int'($urandom_range(511));
            end
            cur.de   = ($urandom_range(3) != 0);
            cur.hs   = 1'($urandom_range(1));
            cur.vs   = 1'($urandom_range(1));
            cur.grid = 1'($urandom_range(1));
            cur.rd   = 1'($urandom_range(1));
            if ($urandom_range(49) == 0) cur.req = !cur.req;
            tick();
        end

        // Address and live-cell colour for pixel (17,9)
        cur = '{default: 0};
        cur.cx = 100; cur.x = 17; cur.y = 9; cur.de = 1; cur.rd = 1;
        tick();
        chk("addr_17_9", 16'(cell_addr), 16'd82);
        cur.x = 24;
        tick();
        chk("green_17_9", 16'(vga_g), 16'd7);

        // Grid line on a dead cell, then grid disabled
        cur.x = 16; cur.y = 20; cur.rd = 0; cur.grid = 1;
        tick();
        cur.grid = 0;
        tick();
        chk("grid_on", 16'({vga_r, vga_g, vga_b}), 16'h25);
        tick();
        chk("grid_off", 16'({vga_r, vga_g, vga_b}), 16'h00);

        // Cursor border at cell (2,1)
        cur.cx = 2; cur.cy = 1; cur.x = 16; cur.y = 8; cur.rd = 1;
        tick();
        cur.x = 30;
        tick();
        chk("cursor_red", 16'(vga_r), 16'd7);

        // Cursor off-grid: no red anywhere
        cur.cx = 90; cur.cy = 1;
        for (int i = 0; i < 400; i++) begin
            cur.x  = int'($urandom_range(1023));
            cur.y  = int'($urandom_range(511));
            cur.de = 1'($urandom_range(1));
            cur.rd = 1'($urandom_range(1));
            tick();
            chk("no_red", 16'(vga_r == 3'd7), 16'd0);
        end

        // Swap raised mid-frame, honoured at the frame end, then held for 3 frames
        do_reset();
        cur = '{default: 0};
        cur.cx = 100; cur.x = 100; cur.y = 200; cur.de = 1;
        tick();
        tick();
        cur.req = 1;
        tick();
        tick();
        chk("no_early_swap", 16'(cell_bank), 16'd0);
        frame_event();
        chk("swap_bank", 16'(cell_bank), 16'd1);
        chk("swap_ack_hi", 16'(swap_ack), 16'd1);
        cur.y = 0; cur.x = 0; cur.de = 1;
        tick();
        chk("swap_ack_lo", 16'(swap_ack), 16'd0);
        for (int f = 0; f < 3; f++) begin
            cur.y = 100; cur.de = 1;
            tick();
            tick();
            frame_event();
        end
        chk("held_no_swap", 16'(cell_bank), 16'd1);

        // Request rising on the frame-end cycle swaps immediately
        cur.req = 0; cur.y = 50; cur.de = 1;
        tick();
        tick();
        cur.y = 479; cur.de = 1;
        tick();
        cur.de = 0; cur.req = 1;
        tick();
        chk("coinc_bank", 16'(cell_bank), 16'd0);
        chk("coinc_ack", 16'(swap_ack), 16'd1);

        // Park in PENDING, then reset: no swap may survive
        cur.req = 0; cur.y = 10; cur.de = 1;
        tick();
        cur.req = 1;
        tick();
        tick();
        do_reset();
        chk("pend_rst_ack", 16'(swap_ack), 16'd0);
        cur.req = 0;
        tick();
        frame_event();
        chk("pend_rst_bank", 16'(cell_bank), 16'd0);
        chk("pend_rst_ack2", 16'(swap_ack), 16'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
